step_timer: RTL
===============

STEP_TIMER -- requirements
Module: step_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, 24_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter FAST_DIV, 100, speed-up factor applied when i_fast=1.
REQ-003 SHALL have parameter TW, 16, width of duration/elapsed/remaining counts.
REQ-004 SHALL have parameter NSTEP, 4, number of wash steps tracked; SW=$clog2(NSTEP).
REQ-005 SHALL have clk  input  1  system clock.
REQ-006 SHALL have reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have i_start  input  1  one-cycle request to begin timing a step.
REQ-008 SHALL have i_pause  input  1  level; hold count while high.
REQ-009 SHALL have i_abort  input  1  one-cycle cancel of running step.
REQ-010 SHALL have i_fast  input  1  level; select tick period CLK_HZ/FAST_DIV cycles.
REQ-011 SHALL have i_step  input  SW  step index, sampled with i_start.
REQ-012 SHALL have i_duration  input  TW  step length in ticks, sampled with i_start.
REQ-013 SHALL have i_clear  input  1  one-cycle clear of all o_step_done flags.
REQ-014 SHALL have o_busy  output  1  high in RUN or PAUSE.
REQ-015 SHALL have o_done  output  1  one-cycle pulse on step completion.
REQ-016 SHALL have o_step_done  output  NSTEP  sticky per-step completion flags.
REQ-017 SHALL have o_elapsed  output  TW  ticks counted in current step.
REQ-018 SHALL have o_remaining  output  TW  latched duration minus o_elapsed.
REQ-019 SHALL have o_tick  output  1  one-cycle pulse per tick (free-running, for display).

Function
REQ-020 Tick generator SHALL be a single clk-domain prescaler; no derived clocks; tick period CLK_HZ cycles (i_fast=0) or CLK_HZ/FAST_DIV cycles (i_fast=1).
REQ-021 Prescaler SHALL restart from 0 on accepted i_start and on any change of i_fast, so first tick comes one full period later.
REQ-022 FSM states SHALL be IDLE, RUN, PAUSE, DONE.
REQ-023 IDLE: i_start=1 -> latch i_step, i_duration; o_elapsed<=0; next RUN (or DONE if i_duration=0).
REQ-024 RUN: tick with o_elapsed+1==duration -> o_elapsed<=duration, next DONE; other tick -> o_elapsed+1; i_pause=1 -> PAUSE.
REQ-025 PAUSE: ticks ignored, o_elapsed held; i_pause=0 -> RUN; prescaler keeps its phase.
REQ-026 DONE: one cycle; o_done=1, o_step_done[step]<=1; next IDLE.
REQ-027 Priority in RUN/PAUSE SHALL be i_abort > tick-completion > i_pause > tick.
REQ-028 i_abort SHALL return to IDLE next cycle, o_elapsed<=0, no o_done, no flag set; ignored in IDLE/DONE.
REQ-029 i_start while not IDLE SHALL be ignored (no relatch, no prescaler restart).
REQ-030 o_remaining SHALL equal latched duration minus o_elapsed, TW-bit, never underflow; 0 in IDLE.
REQ-031 i_clear SHALL zero o_step_done; if coincident with DONE, the new flag SHALL survive.
REQ-032 o_elapsed SHALL be 0 in IDLE.

Reset
REQ-033 reset low SHALL force state IDLE, prescaler 0, o_busy=0, o_done=0, o_tick=0, o_step_done=0, o_elapsed=0, o_remaining=0, latched step/duration 0.
REQ-034 reset SHALL be synchronised to clk (assert async, deassert via 2-flop); assertion mid-step SHALL discard all progress.

Structure
REQ-035 State encoding enum and tick-divisor helper SHALL live in package step_timer_pkg.
REQ-036 Prescaler SHALL be sub-module tick_gen (params CLK_HZ, FAST_DIV; ports clk, reset, i_fast, i_restart, o_tick).

Verification (CLK_HZ=100, FAST_DIV=10)
REQ-037 start step 2, dur 3, fast=0 -> o_done at 300 cycles after start (+/-1), o_step_done=4'b0100, o_remaining 3,2,1,0.
REQ-038 dur 0 -> o_done two cycles after start, o_elapsed stays 0.
REQ-039 dur 5, pause after tick 2 for 500 cycles -> o_elapsed holds 2; done 300 cycles after resume plus residual phase.
REQ-040 dur 4, abort after tick 1 -> IDLE, no o_done, o_step_done unchanged; new start accepted next cycle.
REQ-041 fast=1, dur 4 -> o_done 40 cycles after start; second i_start while busy ignored.
REQ-042 reset pulse mid-RUN -> all outputs 0 within 1 cycle; i_clear coincident with DONE of step 1 -> o_step_done=4'b0010.

Source files
------------

// File: rtl/step_timer_pkg.sv
// step_timer_pkg
// Shared definitions for the wash-step timer: the controller state encoding
// and the helper that turns a clock frequency and speed-up factor into a
// tick period measured in clk cycles.
package step_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Tick period in clk cycles. The prescaler schedules its registered tick
    // one cycle ahead of the period boundary, which needs at least three
    // cycles of period, so smaller results are raised to three. A zero
    // speed-up factor is treated as "no speed-up".
    function automatic int unsigned tick_period(input int unsigned clk_hz,
                                                input int unsigned fast_div,
                                                input logic        fast);
        int unsigned p;
        if (fast && (fast_div != 0)) begin
            p = clk_hz / fast_div;
        end else begin
            p = clk_hz;
        end
        if (p < 3) begin
            p = 3;
        end
        return p;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
// Single clock-domain prescaler producing a one-cycle tick pulse every
// CLK_HZ cycles (i_fast=0) or CLK_HZ/FAST_DIV cycles (i_fast=1).
//
// Ports
//   clk       : system clock
//   reset     : asynchronous, active-low reset (already synchronised)
//   i_fast    : level, selects the shortened tick period
//   i_restart : one-cycle request to restart the period from zero
//   o_tick    : one-cycle tick pulse
module tick_gen
    import step_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 24_000_000,
    parameter int unsigned FAST_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic i_fast,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned P_SLOW = tick_period(CLK_HZ, FAST_DIV, 1'b0);
    localparam int unsigned P_FAST = tick_period(CLK_HZ, FAST_DIV, 1'b1);
    localparam int unsigned P_MAX  = (P_SLOW > P_FAST) ? P_SLOW : P_FAST;
    localparam int unsigned CW     = $clog2(P_MAX);

    localparam logic [CW-1:0] LAST_SLOW = CW'(P_SLOW - 1);
    localparam logic [CW-1:0] LAST_FAST = CW'(P_FAST - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;
    logic          fast_q;
    logic          restart;

    assign last    = i_fast ? LAST_FAST : LAST_SLOW;
    assign restart = i_restart | (i_fast != fast_q);

    // The cycle that carries the restart request counts as the first cycle
    // of the new period, so the counter reloads with 1. The tick register is
    // set one count before the period boundary so that logic sampling it
    // acts exactly one full period after the restart cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            fast_q <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            fast_q <= i_fast;
            if (restart) begin
                cnt    <= ONE;
                o_tick <= 1'b0;
            end else begin
                o_tick <= (cnt == (last - ONE));
                cnt    <= (cnt >= last) ? '0 : (cnt + ONE);
            end
        end
    end

endmodule

// File: rtl/step_timer.sv
// step_timer
// Times one wash step at a time: counts ticks up to a latched duration,
// supports pause/abort, pulses o_done on completion and keeps a sticky
// per-step completion flag.
//
// Ports
//   clk         : system clock
//   reset       : asynchronous, active-low reset (synchronised internally)
//   i_start     : one-cycle request to begin timing step i_step
//   i_pause     : level, hold the count while high
//   i_abort     : one-cycle cancel of the running step
//   i_fast      : level, select the shortened tick period
//   i_step      : step index, sampled with i_start
//   i_duration  : step length in ticks, sampled with i_start
//   i_clear     : one-cycle clear of all o_step_done flags
//   o_busy      : high while running or paused
//   o_done      : one-cycle completion pulse
//   o_step_done : sticky per-step completion flags
//   o_elapsed   : ticks counted in the current step
//   o_remaining : latched duration minus o_elapsed
//   o_tick      : free-running tick pulse for display
module step_timer
    import step_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 24_000_000,
    parameter int unsigned FAST_DIV = 100,
    parameter int unsigned TW       = 16,
    parameter int unsigned NSTEP    = 4,
    parameter int unsigned SW       = (NSTEP > 1) ? $clog2(NSTEP) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_abort,
    input  logic             i_fast,
    input  logic [SW-1:0]    i_step,
    input  logic [TW-1:0]    i_duration,
    input  logic             i_clear,
    output logic             o_busy,
    output logic             o_done,
    output logic [NSTEP-1:0] o_step_done,
    output logic [TW-1:0]    o_elapsed,
    output logic [TW-1:0]    o_remaining,
    output logic             o_tick
);

    localparam logic [TW-1:0] ONE_TW = TW'(1);

    logic [1:0]       rst_sync;
    logic             rst_n;
    state_t           state;
    logic [SW-1:0]    step_q;
    logic [TW-1:0]    dur_q;
    logic [TW-1:0]    elapsed_inc;
    logic [NSTEP-1:0] step_bit;
    logic             start_accept;
    logic             tick_last;

    // Reset asserts immediately and releases two clk edges later, so every
    // register below leaves reset on the same, clean edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    assign start_accept = (state == IDLE) && i_start;
    assign elapsed_inc  = o_elapsed + ONE_TW;
    assign tick_last    = o_tick && (elapsed_inc == dur_q);
    assign step_bit     = NSTEP'(1) << step_q;

    tick_gen #(
        .CLK_HZ   (CLK_HZ),
        .FAST_DIV (FAST_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (rst_n),
        .i_fast    (i_fast),
        .i_restart (start_accept),
        .o_tick    (o_tick)
    );

    // Controller. All outputs are registered alongside the state, so
    // o_remaining is updated together with o_elapsed rather than derived.
    // A clear coincident with completion wipes the old flags but keeps the
    // one being set by the finishing step. Ticks are ignored while paused;
    // the prescaler keeps running so resuming preserves its phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step_q      <= '0;
            dur_q       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_step_done <= '0;
            o_elapsed   <= '0;
            o_remaining <= '0;
        end else begin
            o_done <= 1'b0;
            if (i_clear) begin
                o_step_done <= '0;
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        step_q    <= i_step;
                        dur_q     <= i_duration;
                        o_elapsed <= '0;
                        if (i_duration == '0) begin
                            state       <= DONE;
                            o_busy      <= 1'b0;
                            o_remaining <= '0;
                        end else begin
                            state       <= RUN;
                            o_busy      <= 1'b1;
                            o_remaining <= i_duration;
                        end
                    end
                end

                RUN: begin
                    if (i_abort) begin
                        state       <= IDLE;
                        o_busy      <= 1'b0;
                        o_elapsed   <= '0;
                        o_remaining <= '0;
                    end else if (tick_last) begin
                        state       <= DONE;
                        o_busy      <= 1'b0;
                        o_elapsed   <= dur_q;
                        o_remaining <= '0;
                    end else if (i_pause) begin
                        state <= PAUSE;
                    end else if (o_tick) begin
                        o_elapsed   <= elapsed_inc;
                        o_remaining <= dur_q - elapsed_inc;
                    end
                end

                PAUSE: begin
                    if (i_abort) begin
                        state       <= IDLE;
                        o_busy      <= 1'b0;
                        o_elapsed   <= '0;
                        o_remaining <= '0;
                    end else if (!i_pause) begin
                        state <= RUN;
                    end
                end

                DONE: begin
                    state       <= IDLE;
                    o_done      <= 1'b1;
                    o_step_done <= (i_clear ? '0 : o_step_done) | step_bit;
                    o_elapsed   <= '0;
                    o_remaining <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
